// File: rtl/mult_parity_responder.sv
// Parity-protected iterative 16x16 signed multiplier, responder side.
// Optional macro MULT_ARG_PARITY_CHECK_EN enables operand parity checking and the ERR path.
module mult_parity_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] arg_a,
    input  logic        arg_a_parity,
    input  logic [15:0] arg_b,
    input  logic        arg_b_parity,
    input  logic        req,
    output logic        ack,
    output logic [31:0] result,
    output logic        result_parity,
    output logic        result_rdy,
    output logic        arg_parity_error
);

    // Handshake: req is sampled only in IDLE; ack is a one-cycle pulse after the
    // capture edge; result_rdy is a one-cycle strobe with result fields held
    // stable from that strobe until the next capture.
    typedef enum logic [1:0] {IDLE, CALC, ERR, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        ack_q, ack_d;
    logic        rdy_q, rdy_d;
    logic [31:0] result_q, result_d;
    logic        rpar_q, rpar_d;
    logic        perr_q, perr_d;

    logic [16:0] mag_a, mag_b;
    logic [31:0] step_sum;
    logic [31:0] signed_prod;
    logic        par_bad;

`ifdef MULT_ARG_PARITY_CHECK_EN
    assign par_bad = (arg_a_parity != ^arg_a) || (arg_b_parity != ^arg_b);
`else
    logic unused_parity;
    assign unused_parity = arg_a_parity ^ arg_b_parity;
    assign par_bad       = 1'b0;
`endif

    // 17-bit magnitudes so that -32768 maps to +32768 exactly; the largest
    // magnitude never sets bit 16, so 16 multiplier steps cover every operand.
    assign mag_a = arg_a[15] ? (17'd0 - {1'b1, arg_a}) : {1'b0, arg_a};
    assign mag_b = arg_b[15] ? (17'd0 - {1'b1, arg_b}) : {1'b0, arg_b};

    assign step_sum    = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
    assign signed_prod = neg_q ? (32'd0 - step_sum) : step_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        ack_d    = 1'b0;
        rdy_d    = 1'b0;
        result_d = result_q;
        rpar_d   = rpar_q;
        perr_d   = perr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    ack_d    = 1'b1;
                    result_d = 32'd0;
                    rpar_d   = 1'b0;
                    perr_d   = 1'b0;
                    mcand_d  = {15'd0, mag_a};
                    mplier_d = mag_b[15:0];
                    acc_d    = 32'd0;
                    neg_d    = arg_a[15] ^ arg_b[15];
                    cnt_d    = 4'd0;
                    state_d  = par_bad ? ERR : CALC;
                end
            end
            CALC: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    result_d = signed_prod;
                    rpar_d   = ^signed_prod;
                    state_d  = DONE;
                end
            end
`ifdef MULT_ARG_PARITY_CHECK_EN
            ERR: begin
                result_d = 32'd0;
                rpar_d   = 1'b0;
                perr_d   = 1'b1;
                state_d  = DONE;
            end
`endif
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 16'd0;
            acc_q    <= 32'd0;
            neg_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdy_q    <= 1'b0;
            result_q <= 32'd0;
            rpar_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            ack_q    <= ack_d;
            rdy_q    <= rdy_d;
            result_q <= result_d;
            rpar_q   <= rpar_d;
            perr_q   <= perr_d;
        end
    end

    assign ack              = ack_q;
    assign result           = result_q;
    assign result_parity    = rpar_q;
    assign result_rdy       = rdy_q;
    assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_mult_parity_responder.sv
// Randomized scoreboard bench for mult_parity_responder (either parity-check build).
module tb_mult_parity_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] arg_a = '0;
  logic        arg_a_parity = 1'b0;
  logic [15:0] arg_b = '0;
  logic        arg_b_parity = 1'b0;
  logic        req = 1'b0;
  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  mult_parity_responder dut (
    .clk(clk), .rst_n(rst_n),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .req(req), .ack(ack),
    .result(result), .result_parity(result_parity),
    .result_rdy(result_rdy), .arg_parity_error(arg_parity_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rdy_cyc = 0;
  logic [32:0] exp_q[$];  // {parity_error, product}

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed integer multiply, or the error response when parity is checked and wrong.
  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic pa, input logic pb);
    int p;
    p = int'($signed(a)) * int'($signed(b));
`ifdef MULT_ARG_PARITY_CHECK_EN
    if (pa != ^a || pb != ^b) return {1'b1, 32'd0};
`else
    if (pa ^ pb ^ 1'b0 ^ 1'b0) p = p;
`endif
    return {1'b0, p[31:0]};
  endfunction

  // Monitor
  logic        prev_rdy = 1'b0;
  logic [31:0] held_result = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_rdy && !ack) check("result_hold", result, held_result);
      if (result_rdy) begin
        check("rdy_single_cycle", {31'd0, prev_rdy}, 32'd0);
        check("rdy_ack_overlap", {31'd0, ack}, 32'd0);
        last_rdy_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_rdy", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("result", result, e[31:0]);
          check("result_parity", {31'd0, result_parity}, {31'd0, ^e[31:0]});
          check("arg_parity_error", {31'd0, arg_parity_error}, {31'd0, e[32]});
        end
        held_result = result;
      end
      prev_rdy = result_rdy;
    end else begin
      prev_rdy = 1'b0;
    end
  end

  task automatic wait_ack(input int budget, output int ack_cyc);
    ack_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack) begin
        ack_cyc = cyc;
        break;
      end
    end
    checks++;
    if (ack_cyc < 0) begin
      errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles", budget);
    end else begin
      check("clear_at_capture", {arg_parity_error, result_parity, result[29:0]}, 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rdy_timeout: %0d responses outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                         input logic pa, input logic pb);
    int ack_cyc;
    logic [32:0] e;
    @(negedge clk);
    arg_a = a; arg_b = b; arg_a_parity = pa; arg_b_parity = pb; req = 1'b1;
    e = model(a, b, pa, pb);
    exp_q.push_back(e);
    wait_ack(5, ack_cyc);
    req = 1'b0;
    arg_a = 16'($urandom); arg_b = 16'($urandom);
    @(negedge clk);
    check("ack_one_cycle", {31'd0, ack}, 32'd0);
    drain(40);
    if (ack_cyc >= 0) check("latency", 32'(last_rdy_cyc - ack_cyc), e[32] ? 32'd2 : 32'd17);
  endtask

  initial begin
    int c0, c1, c2;
    logic [15:0] a, b;
    logic pa, pb;

    #1;
    check("reset_outputs", {ack, result_parity, result_rdy, arg_parity_error, result[27:0]}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_txn(16'd3, -16'sd4, 1'b0, 1'b0);
    run_txn(16'h8000, 16'h8000, 1'b1, 1'b1);
    run_txn(16'h7FFF, 16'h8000, 1'b1, 1'b1);
    run_txn(16'd1, 16'd2, 1'b0, 1'b1);   // wrong parity on A
    run_txn(16'd0, 16'h8000, 1'b0, 1'b1);

    // Reset 8 cycles into CALC: outputs drop at once, no response for the aborted request.
    @(negedge clk);
    arg_a = 16'd100; arg_b = 16'd200; arg_a_parity = ^16'd100; arg_b_parity = ^16'd200; req = 1'b1;
    wait_ack(5, c0);
    req = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_calc", {ack, result_parity, result_rdy, arg_parity_error, result[27:0]}, 32'd0);
    check("reset_mid_calc_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_txn(16'd5, 16'd7, 1'b0, 1'b1);

    // req held high: back-to-back captures 18 cycles apart.
    @(negedge clk);
    arg_a = 16'hFFFF; arg_b = 16'hFFFF; arg_a_parity = 1'b0; arg_b_parity = 1'b0; req = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(model(16'hFFFF, 16'hFFFF, 1'b0, 1'b0));
    wait_ack(5, c0);
    wait_ack(25, c1);
    wait_ack(25, c2);
    req = 1'b0;
    check("b2b_spacing_1", 32'(c1 - c0), 32'd18);
    check("b2b_spacing_2", 32'(c2 - c1), 32'd18);
    drain(40);

    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1) ? 16'h8000 : 16'h7FFF;
      pa = ^a ^ ($urandom_range(0, 7) == 0);
      pb = ^b ^ ($urandom_range(0, 7) == 0);
      run_txn(a, b, pa, pb);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
